// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-control sequencer gating the CPU enable.
// Optional: CPU_RUN_CTRL_HALT_PC_EN captures the PC at each halt.
module cpu_run_ctrl #(
  parameter int PC_W      = 12,
  parameter int CNT_W     = 32,
  parameter int HOLD_CYC  = 2,
  parameter int START_RUN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc_f,
  input  logic             halt_insn,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] en_cnt,
  output logic [PC_W-1:0]  halt_pc
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LAST =
    4'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           st_q;
  state_t           st_d;
  logic [3:0]       hold_q;
  logic             step_q;
  logic             skip_q;
  logic             skip_d;
  logic             en_d;
  logic             halt_cap;
  logic             step_edge;
  logic             bp_hit;
  logic [CNT_W-1:0] cnt_q;

  assign step_edge = step_req & ~step_q;
  assign bp_hit    = bp_en & (pc_f == bp_addr)
                   & ~skip_q;

  // Next-state, enable and halt-capture decode.
  always_comb begin
    st_d     = st_q;
    skip_d   = skip_q;
    en_d     = 1'b0;
    halt_cap = 1'b0;
    unique case (st_q)
      S_HOLD: begin
        if (hold_q == HOLD_LAST)
          st_d = (START_RUN != 0) ? S_RUN
                                  : S_HALT;
      end
      S_RUN: begin
        en_d = ~(bp_hit | halt_insn);
        if (en_d)
          skip_d = 1'b0;
        if (halt_insn) begin
          st_d     = S_DONE;
          halt_cap = 1'b1;
        end else if (bp_hit || !run_req) begin
          st_d     = S_HALT;
          halt_cap = 1'b1;
        end
      end
      S_HALT: begin
        if (halt_insn) begin
          st_d     = S_DONE;
          halt_cap = 1'b1;
        end else if (run_req) begin
          st_d   = S_RUN;
          skip_d = 1'b1;
        end else if (step_edge) begin
          en_d = 1'b1;
        end
      end
      S_DONE: begin
        st_d = S_DONE;
      end
      default: begin
        st_d = S_HOLD;
      end
    endcase
  end

  // State, hold window, step edge and skip flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_HOLD;
      hold_q <= 4'd0;
      step_q <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      step_q <= step_req;
      skip_q <= skip_d;
      if (st_q == S_HOLD)
        hold_q <= hold_q + 4'd1;
      else
        hold_q <= 4'd0;
    end
  end

  // Saturating count of enabled cycles.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (en_d && (cnt_q != '1))
      cnt_q <= cnt_q + CNT_ONE;
  end

  assign cpu_en = en_d;
  assign state  = st_q;
  assign en_cnt = cnt_q;

`ifdef CPU_RUN_CTRL_HALT_PC_EN
  logic [PC_W-1:0] hpc_q;

  // Latch fetch PC on every halt event.
  always_ff @(posedge clk) begin
    if (rst)
      hpc_q <= '0;
    else if (halt_cap)
      hpc_q <= pc_f;
  end

  assign halt_pc = hpc_q;
`else
  assign halt_pc = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed run-control scenarios checked
// against a cycle model plus literal expectations.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_req;
  logic        step_req;
  logic        bp_en;
  logic [11:0] bp_addr;
  logic [11:0] pc_f;
  logic        halt_insn;
  logic        cpu_en;
  logic [1:0]  state;
  logic [31:0] en_cnt;
  logic [11:0] halt_pc;
  logic        s_en;
  logic [1:0]  s_state;
  logic [3:0]  s_cnt;
  logic [11:0] s_hpc;

  int n_chk = 0;
  int n_fail = 0;
  logic en_seen = 1'b0;
  bit auto_pc = 1'b1;

  cpu_run_ctrl u_dut (
    .clk(clk), .rst(rst),
    .run_req(run_req), .step_req(step_req),
    .bp_en(bp_en), .bp_addr(bp_addr),
    .pc_f(pc_f), .halt_insn(halt_insn),
    .cpu_en(cpu_en), .state(state),
    .en_cnt(en_cnt), .halt_pc(halt_pc)
  );

  cpu_run_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .run_req(run_req), .step_req(step_req),
    .bp_en(bp_en), .bp_addr(bp_addr),
    .pc_f(pc_f), .halt_insn(halt_insn),
    .cpu_en(s_en), .state(s_state),
    .en_cnt(s_cnt), .halt_pc(s_hpc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Behavioural model: mode names as ints,
  // count as unbounded int, hold as countdown.
  int  m_mode;
  int  m_left;
  int  m_cnt;
  bit  m_skip;
  bit  m_key;
  bit  m_valid = 1'b0;
  int  m_hpc;

  always begin
    bit edge_s;
    bit hit;
    bit en;
    int sat;
    @(negedge clk);
    en_seen = cpu_en;
    edge_s = step_req && !m_key;
    hit = bp_en && (pc_f == bp_addr) && !m_skip;
    en = 1'b0;
    if (m_mode == 2)
      en = !(hit || halt_insn);
    if (m_mode == 1)
      en = edge_s && !run_req && !halt_insn;
    sat = (m_cnt > 15) ? 15 : m_cnt;
    if (m_valid) begin
      check("m_cpu_en", 32'(cpu_en), 32'(en));
      check("m_state", 32'(state), 32'(m_mode));
      check("m_en_cnt", en_cnt, 32'(m_cnt));
      check("m_sat_cnt", 32'(s_cnt), 32'(sat));
      check("m_sat_en", 32'(s_en), 32'(en));
`ifdef CPU_RUN_CTRL_HALT_PC_EN
      check("m_halt_pc", 32'(halt_pc), 32'(m_hpc));
`else
      check("m_halt_pc", 32'(halt_pc), 32'd0);
`endif
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b1;
      m_mode = 0;
      m_left = 2;
      m_cnt = 0;
      m_skip = 1'b0;
      m_key = 1'b0;
      m_hpc = 0;
    end else begin
      m_key = step_req;
      if (en) m_cnt++;
      case (m_mode)
        0: begin
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
        2: begin
          if (en) m_skip = 1'b0;
          if (halt_insn || hit || !run_req) begin
            m_mode = halt_insn ? 3 : 1;
            m_hpc = int'(pc_f);
          end
        end
        1: begin
          if (halt_insn) begin
            m_mode = 3;
            m_hpc = int'(pc_f);
          end else if (run_req) begin
            m_mode = 2;
            m_skip = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // One clock: CPU stand-in advances PC when enabled.
  task automatic tick();
    logic e;
    @(negedge clk);
    #1 e = en_seen;
    @(posedge clk);
    #1;
    if (auto_pc && e) pc_f = pc_f + 12'd4;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run_req = 1'b1;
    step_req = 1'b0; bp_en = 1'b0;
    bp_addr = 12'h0; pc_f = 12'h0;
    halt_insn = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_en", 32'(cpu_en), 32'd0);
    check("rst_cnt", en_cnt, 32'd0);
    tick();
    #1 check("hold2_en", 32'(cpu_en), 32'd0);
    tick();
    #1 check("run_state", 32'(state), 32'd2);
    check("run_en", 32'(cpu_en), 32'd1);
    ticks(3);
    #1 check("run3_cnt", en_cnt, 32'd3);
    bp_en = 1'b1; bp_addr = 12'h010;
    tick();
    #1 check("bp_pc", 32'(pc_f), 32'h010);
    check("bp_en_drop", 32'(cpu_en), 32'd0);
    run_req = 1'b0;
    tick();
    #1 check("bp_halted", 32'(state), 32'd1);
`ifdef CPU_RUN_CTRL_HALT_PC_EN
    check("bp_hpc", 32'(halt_pc), 32'h010);
`endif
    tick();
    run_req = 1'b1;
    #1 check("halt_en", 32'(cpu_en), 32'd0);
    tick();
    #1 check("resume_st", 32'(state), 32'd2);
    check("resume_en", 32'(cpu_en), 32'd1);
    tick();
    #1 check("past_bp", 32'(pc_f), 32'h014);
    check("past_en", 32'(cpu_en), 32'd1);
    run_req = 1'b0; bp_en = 1'b0;
    tick();
    #1 check("stop_st", 32'(state), 32'd1);
    check("stop_cnt", en_cnt, 32'd6);
    step_req = 1'b1;
    #1 check("step_en", 32'(cpu_en), 32'd1);
    tick();
    #1 check("held_en", 32'(cpu_en), 32'd0);
    check("step_cnt", en_cnt, 32'd7);
    ticks(3);
    step_req = 1'b0;
    #1 check("held5_cnt", en_cnt, 32'd7);
    tick();
    step_req = 1'b1;
    #1 check("step2_en", 32'(cpu_en), 32'd1);
    tick();
    step_req = 1'b0;
    #1 check("step2_cnt", en_cnt, 32'd8);
    tick();
    run_req = 1'b1; step_req = 1'b1;
    #1 check("coll_en", 32'(cpu_en), 32'd0);
    tick();
    #1 check("coll_st", 32'(state), 32'd2);
    check("coll_cnt", en_cnt, 32'd8);
    tick();
    #1 check("coll_cnt2", en_cnt, 32'd9);
    tick();
    halt_insn = 1'b1;
    #1 check("ebrk_en", 32'(cpu_en), 32'd0);
    tick();
    halt_insn = 1'b0;
    #1 check("done_st", 32'(state), 32'd3);
    check("done_cnt", en_cnt, 32'd10);
`ifdef CPU_RUN_CTRL_HALT_PC_EN
    check("done_hpc", 32'(halt_pc), 32'h028);
`endif
    run_req = 1'b0; step_req = 1'b0;
    tick();
    run_req = 1'b1;
    tick();
    step_req = 1'b1;
    #1 check("done_step", 32'(cpu_en), 32'd0);
    tick();
    #1 check("done_sticky", 32'(state), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0; step_req = 1'b0;
    #1 check("rst2_state", 32'(state), 32'd0);
    check("rst2_cnt", en_cnt, 32'd0);
    check("rst2_sat", 32'(s_cnt), 32'd0);
    ticks(22);
    #1 check("sat_main", en_cnt, 32'd20);
    check("sat_cnt", 32'(s_cnt), 32'hF);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
